// File: rtl/palindrome_check_arbiter.sv
// Two-requester round-robin front end for one shared combinational palindrome
// checker, with a registered verdict response and saturating statistics.
module palindrome_check_arbiter #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [N-1:0]     req_data0,
  input  logic [N-1:0]     req_data1,
  output logic [N-1:0]     chk_data,
  input  logic             chk_palindrome,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_palindrome,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] pal_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [N-1:0]     chk_data_q, chk_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_pal_q, rsp_pal_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] pal_q, pal_d;

  logic [1:0]       grant;
  logic             grant_id;
  logic             rsp_fire;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    chk_data_d  = chk_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_pal_d   = rsp_pal_q;
    rsp_valid_d = rsp_valid_q;
    grant       = 2'b00;
    grant_id    = 1'b0;

    case (state_q)
      IDLE: begin
        case (req_valid)
          2'b01:   grant = 2'b01;
          2'b10:   grant = 2'b10;
          2'b11:   grant = prio_q ? 2'b10 : 2'b01;
          default: grant = 2'b00;
        endcase
        grant_id = grant[1];
        if (grant != 2'b00) begin
          chk_data_d = grant_id ? req_data1 : req_data0;
          rsp_id_d   = grant_id;
          prio_d     = ~grant_id;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        rsp_pal_d   = chk_palindrome;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_fire = rsp_valid_q & rsp_ready;

  // Clear takes precedence over a coincident increment.
  always_comb begin
    total_d = total_q;
    pal_d   = pal_q;
    if (clr_cnt) begin
      total_d = '0;
      pal_d   = '0;
    end else if (rsp_fire) begin
      if (total_q != CNT_MAX) total_d = total_q + 1'b1;
      if (rsp_pal_q && (pal_q != CNT_MAX)) pal_d = pal_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      chk_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      rsp_pal_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      total_q     <= '0;
      pal_q       <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      chk_data_q  <= chk_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_pal_q   <= rsp_pal_d;
      rsp_valid_q <= rsp_valid_d;
      total_q     <= total_d;
      pal_q       <= pal_d;
    end
  end

  // Grant is masked while reset is held so no requester sees an accept.
  assign req_ready      = rst_n ? grant : 2'b00;
  assign chk_data       = chk_data_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_palindrome = rsp_pal_q;
  assign total_cnt      = total_q;
  assign pal_cnt        = pal_q;

endmodule
